// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: stage control, instruction-memory handshake and the IF/ID-facing outputs.
// master is the fetch unit; slave is whatever drives control and models memory.
interface fetch_unit_if;
   logic [1:0]  ctr;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] n_pc;
   logic [31:0] isn;
   logic        isn_valid;
   logic        empty;
   logic        full;

   modport master (
      input  ctr, redirect, redirect_pc, imem_ack, imem_rvalid, imem_rdata,
      output imem_req, imem_addr, n_pc, isn, isn_valid, empty, full
   );

   modport slave (
      output ctr, redirect, redirect_pc, imem_ack, imem_rvalid, imem_rdata,
      input  imem_req, imem_addr, n_pc, isn, isn_valid, empty, full
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one-outstanding imem requests feeding a prefetch FIFO of {PC+4, word}.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_starved counters.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 4,
   parameter logic [31:0] NOP_INST  = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]  perf_fetched,
   output logic [31:0]  perf_starved
`endif
);

   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t           state_q;
   logic [31:0]      fetchPc_q;
   logic [31:0]      reqAddr_q;
   logic             req_q;

   logic [31:0]      bufPc_q  [BUF_DEPTH];
   logic [31:0]      bufIsn_q [BUF_DEPTH];
   logic [PTR_W-1:0] wrPtr_q;
   logic [PTR_W-1:0] rdPtr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   logic             flush;
   logic             bufEmpty;
   logic             push;
   logic             pop;

   // Redirect and ctr=10 both wipe the buffer, including any word landing this cycle.
   assign flush    = bus.redirect || (bus.ctr == 2'b10);
   assign bufEmpty = (count_q == '0);
   assign push     = (state_q == WAIT) && bus.imem_rvalid && !flush;
   assign pop      = (bus.ctr == 2'b00) && !bufEmpty && !bus.redirect;

   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         count_q <= count_d;
         if (flush) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
         end else begin
            if (push) begin
               bufPc_q[wrPtr_q]  <= reqAddr_q + 32'd4;
               bufIsn_q[wrPtr_q] <= bus.imem_rdata;
               wrPtr_q           <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
               rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
         end
      end
   end

   // reqAddr_q doubles as the address of the outstanding request, so WAIT derives n_pc from it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         fetchPc_q <= RESET_PC;
         reqAddr_q <= RESET_PC;
         req_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if ((count_q < DEPTH_CNT) && !bus.redirect) begin
                  state_q   <= REQ;
                  req_q     <= 1'b1;
                  reqAddr_q <= fetchPc_q;
               end
            end
            REQ: begin
               if (bus.imem_ack) begin
                  req_q     <= 1'b0;
                  state_q   <= bus.redirect ? DROP : WAIT;
                  fetchPc_q <= fetchPc_q + 32'd4;
               end else if (bus.redirect) begin
                  reqAddr_q <= bus.redirect_pc;
               end
            end
            WAIT: begin
               if (bus.imem_rvalid) begin
                  state_q <= IDLE;
               end else if (bus.redirect) begin
                  state_q <= DROP;
               end
            end
            DROP: begin
               if (bus.imem_rvalid) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
         endcase
         if (bus.redirect) begin
            fetchPc_q <= bus.redirect_pc;
         end
      end
   end

   // A redirecting cycle never offers the old head downstream.
   always_comb begin
      bus.isn       = NOP_INST;
      bus.n_pc      = 32'h0;
      bus.isn_valid = 1'b0;
      if (!bufEmpty && !bus.redirect) begin
         bus.isn       = bufIsn_q[rdPtr_q];
         bus.n_pc      = bufPc_q[rdPtr_q];
         bus.isn_valid = 1'b1;
      end
   end

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = reqAddr_q;
   assign bus.empty     = bufEmpty;
   assign bus.full      = (count_q == DEPTH_CNT);

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perfFetched_q;
   logic [31:0] perfStarved_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perfFetched_q <= 32'h0;
         perfStarved_q <= 32'h0;
      end else begin
         if (push) begin
            perfFetched_q <= perfFetched_q + 32'd1;
         end
         if ((bus.ctr == 2'b00) && bufEmpty) begin
            perfStarved_q <= perfStarved_q + 32'd1;
         end
      end
   end

   assign perf_fetched = perfFetched_q;
   assign perf_starved = perfStarved_q;
`endif

endmodule
